// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_pkg : shared widths and types for the conv accumulation tree  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package conv_pkg;
   localparam int EXP_SIZE    = 5;
   localparam int MANT_SIZE   = 10;
   localparam int KERNEL_SIZE = 3;
   localparam int NUM_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
   localparam int SUM_GROWTH  = 4;
   localparam int EXP_W       = EXP_SIZE + 1;
   localparam int PROD_W      = 2 * MANT_SIZE + 1;
   localparam int ACC_W       = PROD_W + SUM_GROWTH + 1;

   typedef logic [PROD_W-1:0] prod_mag_t;
   typedef logic [EXP_W-1:0]  prod_exp_t;
   typedef logic [ACC_W-1:0]  acc_t;

   function automatic prod_exp_t exp_max(input prod_exp_t a, input prod_exp_t b);
      return (a > b) ? a : b;
   endfunction
endpackage
`default_nettype wire

// File: rtl/conv_align_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_align_lane : align one product to emax, clamp, apply sign     |
// | Optional: CONV_ACC_FLUSH_ZERO_EN zeroes lanes with exponent 0      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv_align_lane
   import conv_pkg::*;
(
   input  prod_exp_t i_emax,
   input  prod_mag_t i_mag,
   input  logic      i_sign,
   input  prod_exp_t i_exp,
   output acc_t      o_aligned
);
   prod_exp_t w_dist;
   prod_mag_t w_shifted;
   acc_t      w_ext;
   logic      w_kill;

   always_comb begin
      w_dist = i_emax - i_exp;
`ifdef CONV_ACC_FLUSH_ZERO_EN
      w_kill = (i_exp == '0);
`else
      w_kill = 1'b0;
`endif
      // Shifts of the full product width or more leave nothing behind
      if (w_kill || (w_dist >= prod_exp_t'(PROD_W)))
         w_shifted = '0;
      else
         w_shifted = i_mag >> w_dist;
      w_ext     = {{(ACC_W-PROD_W){1'b0}}, w_shifted};
      o_aligned = i_sign ? (-w_ext) : w_ext;
   end
endmodule
`default_nettype wire

// File: rtl/conv_acc_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_acc_tree : 9-lane align + 4-stage adder tree, valid/ready     |
// | Optional: CONV_ACC_FLUSH_ZERO_EN (see conv_align_lane)             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv_acc_tree #(
   parameter int EXP_SIZE    = conv_pkg::EXP_SIZE,
   parameter int MANT_SIZE   = conv_pkg::MANT_SIZE,
   parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
   parameter int SUM_GROWTH  = conv_pkg::SUM_GROWTH
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*(2*MANT_SIZE+1)-1:0]  p_mag,
   input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                  p_sign,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*(EXP_SIZE+1)-1:0]     p_exp,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic                                                sum_sign,
   output logic [2*MANT_SIZE+SUM_GROWTH:0]                     sum_mag,
   output logic [EXP_SIZE:0]                                   sum_exp
);
   import conv_pkg::*;

   logic                w_advance;

   prod_mag_t           r_s1_mag [NUM_TAPS];
   prod_exp_t           r_s1_exp [NUM_TAPS];
   logic [NUM_TAPS-1:0] r_s1_sign;
   logic                r_s1_valid;
   prod_exp_t           w_lvl1 [4];
   prod_exp_t           w_lvl2 [2];
   prod_exp_t           w_emax;

   acc_t                w_aligned [NUM_TAPS];
   acc_t                r_s2_acc  [NUM_TAPS];
   prod_exp_t           r_s2_emax;
   logic                r_s2_valid;

   acc_t                w_part    [3];
   acc_t                r_s3_part [3];
   prod_exp_t           r_s3_emax;
   logic                r_s3_valid;

   acc_t                w_sum;
   logic [ACC_W-2:0]    w_abs;
   logic                r_out_valid;
   logic                r_sum_sign;
   logic [ACC_W-2:0]    r_sum_mag;
   prod_exp_t           r_sum_exp;

   // Every stage, bubbles included, moves only when the output slot frees up
   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance;

   always_comb begin
      for (int n = 0; n < 4; n++)
         w_lvl1[n] = exp_max(r_s1_exp[2*n], r_s1_exp[2*n+1]);
      w_lvl2[0] = exp_max(w_lvl1[0], w_lvl1[1]);
      w_lvl2[1] = exp_max(w_lvl1[2], w_lvl1[3]);
      w_emax    = exp_max(exp_max(w_lvl2[0], w_lvl2[1]), r_s1_exp[NUM_TAPS-1]);
   end

   generate
      for (genvar g = 0; g < NUM_TAPS; g++) begin : g_lane
         conv_align_lane u_lane (
            .i_emax    (w_emax),
            .i_mag     (r_s1_mag[g]),
            .i_sign    (r_s1_sign[g]),
            .i_exp     (r_s1_exp[g]),
            .o_aligned (w_aligned[g])
         );
      end
      for (genvar g = 0; g < 3; g++) begin : g_group
         assign w_part[g] = r_s2_acc[3*g] + r_s2_acc[3*g+1] + r_s2_acc[3*g+2];
      end
   endgenerate

   assign w_sum = r_s3_part[0] + r_s3_part[1] + r_s3_part[2];
   assign w_abs = w_sum[ACC_W-1] ? (ACC_W-1)'(-w_sum) : w_sum[ACC_W-2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s3_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_sum_sign  <= 1'b0;
         r_sum_mag   <= '0;
         r_sum_exp   <= '0;
      end else if (w_advance) begin
         r_s1_valid <= in_valid;
         for (int n = 0; n < NUM_TAPS; n++) begin
            r_s1_mag[n] <= p_mag[n*PROD_W +: PROD_W];
            r_s1_exp[n] <= p_exp[n*EXP_W +: EXP_W];
         end
         r_s1_sign <= p_sign;

         r_s2_valid <= r_s1_valid;
         r_s2_acc   <= w_aligned;
         r_s2_emax  <= w_emax;

         r_s3_valid <= r_s2_valid;
         r_s3_part  <= w_part;
         r_s3_emax  <= r_s2_emax;

         r_out_valid <= r_s3_valid;
         r_sum_sign  <= w_sum[ACC_W-1];
         r_sum_mag   <= w_abs;
         r_sum_exp   <= r_s3_emax;
      end
   end

   assign out_valid = r_out_valid;
   assign sum_sign  = r_sum_sign;
   assign sum_mag   = r_sum_mag;
   assign sum_exp   = r_sum_exp;
endmodule
`default_nettype wire

// File: tb/tb_conv_acc_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv_acc_tree : directed self-checking bench for conv_acc_tree  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_conv_acc_tree;
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [188:0] p_mag;
   logic [8:0]   p_sign;
   logic [53:0]  p_exp;
   logic         out_valid;
   logic         out_ready;
   logic         sum_sign;
   logic [24:0]  sum_mag;
   logic [5:0]   sum_exp;

   logic [20:0]  lane_mag  [9];
   logic         lane_sign [9];
   logic [5:0]   lane_exp  [9];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   conv_acc_tree dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p_mag     (p_mag),
      .p_sign    (p_sign),
      .p_exp     (p_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_sign  (sum_sign),
      .sum_mag   (sum_mag),
      .sum_exp   (sum_exp)
   );

   always_comb begin
      p_mag  = '0;
      p_sign = '0;
      p_exp  = '0;
      for (int n = 0; n < 9; n++) begin
         p_mag[n*21 +: 21] = lane_mag[n];
         p_sign[n]         = lane_sign[n];
         p_exp[n*6 +: 6]   = lane_exp[n];
      end
   end

   task automatic set_all(input logic [20:0] m, input logic s, input logic [5:0] e);
      for (int n = 0; n < 9; n++) begin
         lane_mag[n]  = m;
         lane_sign[n] = s;
         lane_exp[n]  = e;
      end
   endtask

   // Presents the current lanes for one accepted window and returns the result
   task automatic send_one(output logic o_sign, output logic [24:0] o_mag,
                           output logic [5:0] o_exp, output int o_lat);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      o_lat    = 1;
      while (!out_valid && o_lat < 20) begin
         @(posedge clk); #1;
         o_lat++;
      end
      o_sign = sum_sign;
      o_mag  = sum_mag;
      o_exp  = sum_exp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_all(21'h0, 1'b0, 6'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      n_vec++; if (sum_mag !== 25'h0) begin n_bad++; $display("FAIL reset_sum_mag: got %0h expected 0", sum_mag); end
      n_vec++; if (sum_sign !== 1'b0) begin n_bad++; $display("FAIL reset_sum_sign: got %0b expected 0", sum_sign); end
      n_vec++; if (sum_exp !== 6'd0) begin n_bad++; $display("FAIL reset_sum_exp: got %0d expected 0", sum_exp); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_equal_exp();
      logic s; logic [24:0] m; logic [5:0] e; int lat;
      set_all(21'h100000, 1'b0, 6'd15);
      send_one(s, m, e, lat);
      n_vec++; if (lat != 4) begin n_bad++; $display("FAIL equal_latency: got %0d expected 4", lat); end
      n_vec++; if (m !== 25'h900000) begin n_bad++; $display("FAIL equal_mag: got %0h expected 900000", m); end
      n_vec++; if (e !== 6'd15) begin n_bad++; $display("FAIL equal_exp: got %0d expected 15", e); end
      n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL equal_sign: got %0b expected 0", s); end
   endtask

   task automatic test_cancel();
      logic s; logic [24:0] m; logic [5:0] e; int lat;
      set_all(21'h100000, 1'b0, 6'd15);
      for (int n = 5; n < 9; n++) lane_sign[n] = 1'b1;
      send_one(s, m, e, lat);
      n_vec++; if (m !== 25'h100000) begin n_bad++; $display("FAIL cancel_mag: got %0h expected 100000", m); end
      n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL cancel_sign: got %0b expected 0", s); end
      set_all(21'h100000, 1'b1, 6'd15);
      send_one(s, m, e, lat);
      n_vec++; if (m !== 25'h900000) begin n_bad++; $display("FAIL allneg_mag: got %0h expected 900000", m); end
      n_vec++; if (s !== 1'b1) begin n_bad++; $display("FAIL allneg_sign: got %0b expected 1", s); end
      n_vec++; if (e !== 6'd15) begin n_bad++; $display("FAIL allneg_exp: got %0d expected 15", e); end
      // Zero magnitudes with negative signs must still give a positive zero
      set_all(21'h0, 1'b1, 6'd7);
      send_one(s, m, e, lat);
      n_vec++; if (m !== 25'h0) begin n_bad++; $display("FAIL zero_mag: got %0h expected 0", m); end
      n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL zero_sign: got %0b expected 0", s); end
      n_vec++; if (e !== 6'd7) begin n_bad++; $display("FAIL zero_exp: got %0d expected 7", e); end
   endtask

   task automatic test_align();
      logic s; logic [24:0] m; logic [5:0] e; int lat;
      logic [24:0] want;
      set_all(21'h0, 1'b0, 6'd0);
      lane_mag[0] = 21'h100000; lane_exp[0] = 6'd16;
      lane_mag[1] = 21'h100000; lane_exp[1] = 6'd15;
      lane_mag[2] = 21'h1FFFFF; lane_exp[2] = 6'd0;
`ifdef CONV_ACC_FLUSH_ZERO_EN
      want = 25'h180000;
`else
      want = 25'h18001F;
`endif
      send_one(s, m, e, lat);
      n_vec++; if (m !== want) begin n_bad++; $display("FAIL align_mag: got %0h expected %0h", m, want); end
      n_vec++; if (e !== 6'd16) begin n_bad++; $display("FAIL align_exp: got %0d expected 16", e); end
      n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL align_sign: got %0b expected 0", s); end
      // d = 21 clamps to 0, d = 20 keeps the top bit
      set_all(21'h0, 1'b0, 6'd0);
      lane_mag[0] = 21'h100000; lane_exp[0] = 6'd21;
      lane_mag[1] = 21'h1FFFFF; lane_exp[1] = 6'd0;
      lane_mag[2] = 21'h1FFFFF; lane_exp[2] = 6'd1;
      send_one(s, m, e, lat);
      n_vec++; if (m !== 25'h100001) begin n_bad++; $display("FAIL clamp_mag: got %0h expected 100001", m); end
      n_vec++; if (e !== 6'd21) begin n_bad++; $display("FAIL clamp_exp: got %0d expected 21", e); end
   endtask

   task automatic test_flush_zero();
      logic s; logic [24:0] m; logic [5:0] e; int lat;
      logic [24:0] want1, want2;
      set_all(21'h0, 1'b0, 6'd10);
      lane_mag[0] = 21'h1FFFFF; lane_exp[0] = 6'd0;
      lane_mag[1] = 21'h100000; lane_exp[1] = 6'd10;
`ifdef CONV_ACC_FLUSH_ZERO_EN
      want1 = 25'h100000;
      want2 = 25'h0;
`else
      want1 = 25'h1007FF;
      want2 = 25'h00A3D4;
`endif
      send_one(s, m, e, lat);
      n_vec++; if (m !== want1) begin n_bad++; $display("FAIL flush_mag: got %0h expected %0h", m, want1); end
      n_vec++; if (e !== 6'd10) begin n_bad++; $display("FAIL flush_exp: got %0d expected 10", e); end
      set_all(21'h1234, 1'b0, 6'd0);
      send_one(s, m, e, lat);
      n_vec++; if (m !== want2) begin n_bad++; $display("FAIL allexp0_mag: got %0h expected %0h", m, want2); end
      n_vec++; if (e !== 6'd0) begin n_bad++; $display("FAIL allexp0_exp: got %0d expected 0", e); end
      n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL allexp0_sign: got %0b expected 0", s); end
   endtask

   task automatic test_back_to_back();
      int idx, got, stalls;
      logic held_valid;
      logic [24:0] held_mag, want;
      idx = 0; got = 0; stalls = 0; held_valid = 1'b0; held_mag = '0;
      set_all(21'h0, 1'b0, 6'd15);
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         if (out_valid && stalls < 3) begin out_ready = 1'b0; stalls++; end
         else out_ready = 1'b1;
         if (idx < 6) begin in_valid = 1'b1; lane_mag[0] = 21'((idx + 1) << 10); end
         else in_valid = 1'b0;
         #1;
         if (held_valid) begin
            n_vec++;
            if (out_valid !== 1'b1 || sum_mag !== held_mag) begin
               n_bad++; $display("FAIL stall_hold: got v=%0b mag=%0h expected v=1 mag=%0h", out_valid, sum_mag, held_mag);
            end
         end
         if (out_valid && !out_ready) begin
            n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
         end
         if (stalls == 3) begin
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_gap: got out_valid %0b expected 1", out_valid); end
         end
         if (out_valid && out_ready) begin
            want = 25'((got + 1) << 10);
            n_vec++;
            if (sum_mag !== want || sum_exp !== 6'd15) begin
               n_bad++; $display("FAIL stream_order: got mag=%0h exp=%0d expected mag=%0h exp=15", sum_mag, sum_exp, want);
            end
            got++;
         end
         held_valid = out_valid && !out_ready;
         held_mag   = sum_mag;
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_vec++; if (got != 6) begin n_bad++; $display("FAIL stream_count: got %0d expected 6", got); end
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_extra: got out_valid %0b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      logic s; logic [24:0] m; logic [5:0] e; int lat;
      logic stale;
      set_all(21'h0, 1'b0, 6'd15);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lane_mag[0] = 21'((k + 7) << 10);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %0b expected 0", out_valid); end
      stale = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      n_vec++; if (stale !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stale: got %0b expected 0", stale); end
      lane_mag[0] = 21'h0ABCDE;
      send_one(s, m, e, lat);
      n_vec++; if (lat != 4) begin n_bad++; $display("FAIL rst_mid_latency: got %0d expected 4", lat); end
      n_vec++; if (m !== 25'h0ABCDE) begin n_bad++; $display("FAIL rst_mid_mag: got %0h expected abcde", m); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_equal_exp();
      test_cancel();
      test_align();
      test_flush_zero();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
